// File: rtl/hist_pkg.sv
// Shared histogram framing constants and framer state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hist_pkg;

    localparam int HIST_NWORDS = 2;
    localparam int HIST_WORD_W = 32;
    localparam int FRAME_LEN   = 10;
    localparam int BYTE_IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        ACK,
        WAIT,
        DONE
    } framer_state_t;

endpackage

// File: rtl/hist_frame_byte_mux.sv
// Selects the frame byte for a position: header, shadow bytes LSB-first, checksum.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the byte is used.
module hist_frame_byte_mux
    import hist_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic [BYTE_IDX_W-1:0]               byte_idx,
    input  logic [HIST_NWORDS*HIST_WORD_W-1:0]  shadow,
    input  logic [7:0]                          chk,
    output logic [7:0]                          tx_byte
);

    // Position 0 is the header, 1..8 walk the shadow from its low byte, 9 is CHK.
    always_comb begin
        tx_byte = HDR_BYTE;
        case (byte_idx)
            4'd0:    tx_byte = HDR_BYTE;
            4'd1:    tx_byte = shadow[7:0];
            4'd2:    tx_byte = shadow[15:8];
            4'd3:    tx_byte = shadow[23:16];
            4'd4:    tx_byte = shadow[31:24];
            4'd5:    tx_byte = shadow[39:32];
            4'd6:    tx_byte = shadow[47:40];
            4'd7:    tx_byte = shadow[55:48];
            4'd8:    tx_byte = shadow[63:56];
            default: tx_byte = chk;
        endcase
    end

endmodule

// File: rtl/hist_serial_framer.sv
// Sends the two histogram words as a 10-byte framed UART stream on each host request.
// Latency: header tx_start two cycles after the request strobe when the UART is idle.
// Backpressure: each byte waits for tx_busy low; requests arriving mid-frame are counted and dropped.
module hist_serial_framer
    import hist_pkg::*;
#(
    parameter logic [7:0] CMD_BYTE = 8'h68,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         NWORDS   = HIST_NWORDS
) (
    input  logic                   clk50,
    input  logic                   rstn,
    input  logic [HIST_WORD_W-1:0] hist50 [NWORDS],
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   busy,
    output logic [15:0]            frames_sent,
    output logic [15:0]            req_dropped
);

    localparam logic [BYTE_IDX_W-1:0] LAST_DATA_IDX = BYTE_IDX_W'(FRAME_LEN - 2);
    localparam logic [BYTE_IDX_W-1:0] FRAME_LEN_B   = BYTE_IDX_W'(FRAME_LEN);

    framer_state_t                      state;
    framer_state_t                      state_nxt;
    logic [BYTE_IDX_W-1:0]              byte_idx;
    logic [HIST_NWORDS*HIST_WORD_W-1:0] shadow;
    logic [7:0]                         chk;
    logic [7:0]                         tx_hold;
    logic [7:0]                         cur_byte;
    logic                               cmd_seen;

    assign cmd_seen = rx_valid && (rx_data == CMD_BYTE);
    assign busy     = (state != IDLE);
    // The UART latches tx_data only on tx_start; outside it the last sent byte is held.
    assign tx_data  = tx_start ? cur_byte : tx_hold;

    hist_frame_byte_mux #(
        .HDR_BYTE (HDR_BYTE)
    ) u_byte_mux (
        .byte_idx (byte_idx),
        .shadow   (shadow),
        .chk      (chk),
        .tx_byte  (cur_byte)
    );

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk50) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and tx_start strobe. byte_idx already points past the byte just
    // sent when WAIT is reached, so the frame ends once it equals the frame length.
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        case (state)
            IDLE: if (cmd_seen) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:  state_nxt = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    state_nxt = (byte_idx < FRAME_LEN_B) ? SEND : DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow snapshot, running checksum, byte pointer, held tx byte and counters.
    always_ff @(posedge clk50) begin
        if (!rstn) begin
            byte_idx    <= '0;
            shadow      <= '0;
            chk         <= '0;
            tx_hold     <= '0;
            frames_sent <= '0;
            req_dropped <= '0;
        end else begin
            if (state == LOAD) begin
                shadow   <= {hist50[1], hist50[0]};
                chk      <= '0;
                byte_idx <= '0;
            end
            if (tx_start) begin
                tx_hold  <= cur_byte;
                byte_idx <= byte_idx + 1'b1;
                if ((byte_idx != '0) && (byte_idx <= LAST_DATA_IDX)) begin
                    chk <= chk ^ cur_byte;
                end
            end
            if (state == DONE) begin
                frames_sent <= frames_sent + 16'd1;
            end
            if (cmd_seen && (state != IDLE)) begin
                req_dropped <= req_dropped + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hist_serial_framer.sv
// Directed-plus-random bench for hist_serial_framer with an ideal UART model.
// Latency: checks header launch two cycles after the request and one cycle after busy release.
// Backpressure: UART model holds tx_busy 10 cycles per byte, plus an extended stall.
module tb_hist_serial_framer;

    logic        clk50 = 1'b0;
    logic        rstn;
    logic [31:0] hist50 [2];
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic [15:0] frames_sent;
    logic [15:0] req_dropped;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] got [$];
    int         got_cyc [$];
    int         busy_cnt   = 0;
    logic       hold       = 1'b0;
    logic       start_seen = 1'b0;

    always #5 clk50 = ~clk50;

    hist_serial_framer dut (
        .clk50       (clk50),
        .rstn        (rstn),
        .hist50      (hist50),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .frames_sent (frames_sent),
        .req_dropped (req_dropped)
    );

    // Ideal UART: busy rises the cycle after tx_start and stays up 10 cycles.
    assign tx_busy = (busy_cnt != 0) || hold;

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        start_seen <= tx_start;
        if (tx_start) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
    end

    always @(posedge clk50) begin
        if (start_seen) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk50);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int i = 0;
        while (got.size() < n && i < budget) begin
            tick();
            i++;
        end
        check(tag, got.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i = 0;
        while (busy !== 1'b0 && i < budget) begin
            tick();
            i++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Reference frame: header, word0 bytes LSB-first, word1 bytes LSB-first, XOR of data.
    function automatic void build_frame(input logic [31:0] w0, input logic [31:0] w1,
                                        output logic [7:0] f [10]);
        logic [7:0] x = 8'h00;
        f[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            f[1 + k] = 8'((w0 >> (8 * k)));
            f[5 + k] = 8'((w1 >> (8 * k)));
        end
        for (int k = 1; k <= 8; k++) x ^= f[k];
        f[9] = x;
    endfunction

    task automatic check_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0] f [10];
        logic [7:0] obs;
        build_frame(w0, w1, f);
        check({tag, "_len"}, got.size(), 10);
        for (int i = 0; i < 10; i++) begin
            obs = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'd0, obs}, {24'd0, f[i]});
        end
    endtask

    initial begin
        logic [31:0] w0, w1;
        int t0;
        int exp_frames;
        int exp_drop;

        rstn      = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        hist50[0] = 32'h0;
        hist50[1] = 32'h0;
        repeat (3) tick();

        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", {16'd0, frames_sent}, 32'd0);
        check("rst_dropped", {16'd0, req_dropped}, 32'd0);
        rstn = 1'b1;
        tick();
        exp_frames = 0;
        exp_drop   = 0;

        // Fixed words, header latency, full frame.
        hist50[0] = 32'h04030201;
        hist50[1] = 32'h08070605;
        got.delete(); got_cyc.delete();
        t0 = cyc;
        send_rx(8'h68);
        wait_bytes(10, 400, "t1_bytes");
        wait_idle(40, "t1_idle");
        check("t1_hdr_latency", got_cyc.size() > 0 ? got_cyc[0] - t0 : -1, 2);
        check_frame("t1", 32'h04030201, 32'h08070605);
        check("t1_chk_const", {24'd0, got.size() > 9 ? got[9] : 8'hxx}, 32'h08);
        exp_frames++;
        check("t1_frames", {16'd0, frames_sent}, exp_frames);

        // Inputs churn every cycle; only the LOAD-cycle snapshot may be sent.
        for (int r = 0; r < 2; r++) begin
            got.delete(); got_cyc.delete();
            hist50[0] = $urandom;
            hist50[1] = $urandom;
            send_rx(8'h68);
            w0 = $urandom; w1 = $urandom;
            hist50[0] = w0;
            hist50[1] = w1;
            for (int i = 0; i < 400 && got.size() < 10; i++) begin
                tick();
                hist50[0] = $urandom;
                hist50[1] = $urandom;
            end
            wait_bytes(10, 10, "t2_bytes");
            wait_idle(40, "t2_idle");
            check_frame($sformatf("t2r%0d", r), w0, w1);
            exp_frames++;
            check("t2_frames", {16'd0, frames_sent}, exp_frames);
        end

        // Requests during a frame are dropped; other bytes ignored.
        got.delete(); got_cyc.delete();
        w0 = $urandom; w1 = $urandom;
        hist50[0] = w0; hist50[1] = w1;
        send_rx(8'h68);
        repeat (15) tick();
        send_rx(8'h68);
        repeat (15) tick();
        send_rx(8'h55);
        send_rx(8'h68);
        repeat (15) tick();
        send_rx(8'h68);
        exp_drop += 3;
        wait_bytes(10, 400, "t3_bytes");
        wait_idle(40, "t3_idle");
        check_frame("t3", w0, w1);
        check("t3_dropped", {16'd0, req_dropped}, exp_drop);
        exp_frames++;
        check("t3_frames", {16'd0, frames_sent}, exp_frames);
        repeat (20) tick();
        check("t3_no_extra", got.size(), 10);
        got.delete(); got_cyc.delete();
        w0 = $urandom; w1 = $urandom;
        hist50[0] = w0; hist50[1] = w1;
        send_rx(8'h68);
        wait_bytes(10, 400, "t3b_bytes");
        wait_idle(40, "t3b_idle");
        check_frame("t3b", w0, w1);
        exp_frames++;
        check("t3b_frames", {16'd0, frames_sent}, exp_frames);

        // Long UART stall mid-frame.
        got.delete(); got_cyc.delete();
        w0 = $urandom; w1 = $urandom;
        hist50[0] = w0; hist50[1] = w1;
        send_rx(8'h68);
        wait_bytes(3, 200, "t4_pre");
        tick();
        hold = 1'b1;
        repeat (50) tick();
        check("t4_no_start_held", got.size(), 3);
        hold = 1'b0;
        t0 = cyc;
        tick();
        wait_bytes(4, 20, "t4_resume");
        check("t4_resume_lat", got_cyc.size() > 3 ? got_cyc[3] - t0 : -1, 1);
        wait_bytes(10, 400, "t4_bytes");
        wait_idle(40, "t4_idle");
        check_frame("t4", w0, w1);
        exp_frames++;
        check("t4_frames", {16'd0, frames_sent}, exp_frames);

        // Reset mid-frame abandons the frame.
        got.delete(); got_cyc.delete();
        hist50[0] = $urandom; hist50[1] = $urandom;
        send_rx(8'h68);
        wait_bytes(4, 200, "t5_pre");
        rstn = 1'b0;
        tick();
        check("t5_tx_start", {31'd0, tx_start}, 32'd0);
        check("t5_tx_data", {24'd0, tx_data}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_frames", {16'd0, frames_sent}, 32'd0);
        check("t5_dropped", {16'd0, req_dropped}, 32'd0);
        rstn = 1'b1;
        exp_frames = 0;
        exp_drop   = 0;
        tick();
        got.delete(); got_cyc.delete();
        w0 = $urandom; w1 = $urandom;
        hist50[0] = w0; hist50[1] = w1;
        send_rx(8'h68);
        wait_bytes(10, 400, "t5_bytes");
        wait_idle(40, "t5_idle");
        check_frame("t5", w0, w1);
        exp_frames++;
        check("t5_frames_after", {16'd0, frames_sent}, exp_frames);

        // Counter wrap, then a non-command byte in IDLE.
        force dut.frames_sent = 16'hFFFF;
        tick();
        release dut.frames_sent;
        tick();
        got.delete(); got_cyc.delete();
        w0 = $urandom; w1 = $urandom;
        hist50[0] = w0; hist50[1] = w1;
        send_rx(8'h68);
        wait_bytes(10, 400, "t6_bytes");
        wait_idle(40, "t6_idle");
        check_frame("t6", w0, w1);
        check("t6_frames_wrap", {16'd0, frames_sent}, 32'd0);
        got.delete(); got_cyc.delete();
        send_rx(8'h00);
        repeat (30) tick();
        check("t6_ignore_bytes", got.size(), 0);
        check("t6_ignore_busy", {31'd0, busy}, 32'd0);
        check("t6_dropped", {16'd0, req_dropped}, exp_drop);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
